// File: rtl/uart_plus_bit_changer_pkg.sv
// rtl/uart_plus_bit_changer_pkg.sv - shared FSM state encodings
// State encodings for the UART receiver and the bit-changer frame FSM.
package uart_plus_bit_changer_pkg;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        CH_COLLECT = 2'd0,
        CH_EMBED   = 2'd1,
        CH_DONE    = 2'd2
    } ch_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer
// Samples each bit at its centre; a byte is only published when its stop bit reads high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_rx_serial,
    output logic [7:0] out_rx_byte,
    output logic       out_rx_dv
);
    import uart_plus_bit_changer_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic            meta_q;
    logic            sync_q;
    rx_state_e       state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            dv_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            meta_q <= in_rx_serial;
            sync_q <= meta_q;
            dv_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    // Mid-start re-check rejects short low glitches.
                    if (clk_cnt_q == HALF_CNT) begin
                        clk_cnt_q <= '0;
                        state_q   <= sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q != LAST_CNT) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= sync_q;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            state_q   <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q != LAST_CNT) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q <= '0;
                        if (sync_q) begin
                            byte_q <= shift_q;
                            dv_q   <= 1'b1;
                        end
                        state_q <= RX_CLEANUP;
                    end
                end
                RX_CLEANUP: state_q <= RX_IDLE;
                default:    state_q <= RX_IDLE;
            endcase
        end
    end

    assign out_rx_byte = byte_q;
    assign out_rx_dv   = dv_q;

endmodule

// File: rtl/uart_plus_bit_changer.sv
// rtl/uart_plus_bit_changer.sv - UART receiver feeding a frame bit changer
// Collects FRAME_SIZE received bytes, writes message bit j into the LSB of sample j, publishes the frame.
module uart_plus_bit_changer #(
    parameter int CLKS_PER_BIT = 87,
    parameter int BPS          = 8,
    parameter int FRAME_SIZE   = 1
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_rx_serial,
    input  logic [FRAME_SIZE-1:0]     in_message,
    output logic [7:0]                out_rx_byte,
    output logic                      out_rx_dv,
    output logic [FRAME_SIZE*BPS-1:0] out_frame,
    output logic                      out_ready
);
    import uart_plus_bit_changer_pkg::*;

    localparam int KW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(FRAME_SIZE - 1);

    logic [7:0] rx_byte;
    logic       rx_dv;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_rx_serial (in_rx_serial),
        .out_rx_byte  (rx_byte),
        .out_rx_dv    (rx_dv)
    );

    ch_state_e                 ch_state_q;
    logic [KW-1:0]             k_q;
    logic [FRAME_SIZE*BPS-1:0] work_q;
    logic [FRAME_SIZE*BPS-1:0] frame_q;
    logic [FRAME_SIZE-1:0]     msg_q;
    logic                      ready_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ch_state_q <= CH_COLLECT;
            k_q        <= '0;
            work_q     <= '0;
            frame_q    <= '0;
            msg_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (ch_state_q)
                CH_COLLECT: begin
                    if (rx_dv) begin
                        for (int s = 0; s < FRAME_SIZE; s++) begin
                            if (k_q == KW'(s)) work_q[s*BPS +: BPS] <= rx_byte;
                        end
                        if (k_q == LAST_K) begin
                            k_q        <= '0;
                            msg_q      <= in_message;
                            ch_state_q <= CH_EMBED;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                CH_EMBED: begin
                    // k_q is reused as the sample index while embedding.
                    for (int s = 0; s < FRAME_SIZE; s++) begin
                        if (k_q == KW'(s)) work_q[s*BPS] <= msg_q[s];
                    end
                    if (k_q == LAST_K) begin
                        k_q        <= '0;
                        ch_state_q <= CH_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                CH_DONE: begin
                    frame_q    <= work_q;
                    ready_q    <= 1'b1;
                    k_q        <= '0;
                    ch_state_q <= CH_COLLECT;
                end
                default: ch_state_q <= CH_COLLECT;
            endcase
        end
    end

    assign out_rx_byte = rx_byte;
    assign out_rx_dv   = rx_dv;
    assign out_frame   = frame_q;
    assign out_ready   = ready_q;

endmodule

// File: tb/tb_uart_plus_bit_changer.sv
// tb/tb_uart_plus_bit_changer.sv - self-checking bench for uart_plus_bit_changer
// Two instances (FRAME_SIZE 1 and 2) share one serial line and are checked against a frame model.
module tb_uart_plus_bit_changer;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic       msg1;
    logic [1:0] msg2;

    logic [7:0]  rxb1, rxb2;
    logic        dv1, dv2, rdy1, rdy2;
    logic [7:0]  f1;
    logic [15:0] f2;

    always #50 clk = ~clk;

    uart_plus_bit_changer #(.CLKS_PER_BIT(87), .BPS(8), .FRAME_SIZE(1)) u_dut1 (
        .in_clk(clk), .in_rst(rst), .in_rx_serial(line), .in_message(msg1),
        .out_rx_byte(rxb1), .out_rx_dv(dv1), .out_frame(f1), .out_ready(rdy1)
    );

    uart_plus_bit_changer #(.CLKS_PER_BIT(87), .BPS(8), .FRAME_SIZE(2)) u_dut2 (
        .in_clk(clk), .in_rst(rst), .in_rx_serial(line), .in_message(msg2),
        .out_rx_byte(rxb2), .out_rx_dv(dv2), .out_frame(f2), .out_ready(rdy2)
    );

    logic [7:0]  rxb_a [2];
    logic        dv_a  [2];
    logic        rdy_a [2];
    logic [15:0] frm_a [2];

    assign rxb_a[0] = rxb1;
    assign rxb_a[1] = rxb2;
    assign dv_a[0]  = dv1;
    assign dv_a[1]  = dv2;
    assign rdy_a[0] = rdy1;
    assign rdy_a[1] = rdy2;
    assign frm_a[0] = {8'h00, f1};
    assign frm_a[1] = f2;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        rst_e;
    logic        armed;
    logic [7:0]  exp_byte;
    logic        got    [2];
    logic [7:0]  col    [2][2];
    int          ncol   [2];
    int          fs     [2];
    int          due    [2];
    logic [15:0] mframe [2];
    logic [15:0] nframe [2];
    logic [7:0]  mbyte  [2];
    logic [7:0]  smp;
    logic [1:0]  mbits;

    task automatic chk(input string name, input int unit, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s unit%0d: got 0x%0h expected 0x%0h at cycle %0d", name, unit, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop, input int start_len, input int bit_len);
        armed    = good_stop;
        exp_byte = b;
        got[0]   = 1'b0;
        got[1]   = 1'b0;
        line = 1'b0;
        repeat (start_len) tick();
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (bit_len) tick();
        end
        line = good_stop;
        repeat (bit_len) tick();
        line = 1'b1;
        if (good_stop) chk("dv_seen", 0, {30'd0, got[1], got[0]}, 32'd3);
        armed = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        line  = 1'b1;
        msg1  = 1'b0;
        msg2  = 2'b00;
        armed = 1'b0;
        got[0] = 1'b0;
        got[1] = 1'b0;
        fs[0] = 1;
        fs[1] = 2;
        for (int d = 0; d < 2; d++) begin
            ncol[d] = 0; due[d] = -1; mframe[d] = '0; nframe[d] = '0; mbyte[d] = '0;
        end

        fork
            forever begin
                @(posedge clk);
                rst_e = rst;
                cyc++;
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    if (rst_e) begin
                        ncol[d] = 0; due[d] = -1; mframe[d] = '0; mbyte[d] = '0;
                        chk("dv_in_reset", d + 1, dv_a[d], 0);
                    end else if (dv_a[d]) begin
                        chk("dv_expected", d + 1, armed && !got[d], 1);
                        chk("dv_byte", d + 1, rxb_a[d], exp_byte);
                        got[d]   = 1'b1;
                        mbyte[d] = rxb_a[d];
                        col[d][ncol[d]] = rxb_a[d];
                        ncol[d]++;
                        if (ncol[d] == fs[d]) begin
                            mbits = (d == 0) ? {1'b0, msg1} : msg2;
                            nframe[d] = '0;
                            for (int j = 0; j < fs[d]; j++) begin
                                smp    = col[d][j];
                                smp[0] = mbits[j];
                                nframe[d][j*8 +: 8] = smp;
                            end
                            due[d]  = cyc + fs[d] + 2;
                            ncol[d] = 0;
                        end
                    end
                    if (!rst_e && cyc == due[d]) mframe[d] = nframe[d];
                    chk("rx_byte", d + 1, rxb_a[d], mbyte[d]);
                    chk("ready", d + 1, rdy_a[d], !rst_e && cyc == due[d]);
                    chk("frame", d + 1, frm_a[d], mframe[d]);
                end
            end
        join_none

        repeat (3) tick();
        rst = 1'b0;
        repeat (1000) tick();
        chk("reset_byte", 1, rxb1, 0);
        chk("reset_frame", 2, f2, 0);

        msg1 = 1'b0;
        msg2 = 2'b01;
        send_byte(8'h3F, 1'b1, 96, 86);
        chk("lit_byte_3f", 1, rxb1, 8'h3F);
        chk("lit_frame_3e", 1, f1, 8'h3E);
        chk("model_frame_3e", 1, mframe[0], 16'h003E);
        repeat (20) tick();

        msg1 = 1'b1;
        send_byte(8'hA4, 1'b1, 87, 87);
        chk("lit_frame_a5", 1, f1, 8'hA5);
        chk("lit_frame_a43f", 2, f2, 16'hA43F);
        repeat (20) tick();
        send_byte(8'h3F, 1'b1, 87, 87);
        chk("lit_frame_3f", 1, f1, 8'h3F);
        repeat (20) tick();

        line = 1'b0;
        repeat (30) tick();
        line = 1'b1;
        repeat (200) tick();
        chk("glitch_byte", 1, rxb1, 8'h3F);

        send_byte(8'h55, 1'b0, 87, 87);
        repeat (300) tick();
        chk("framing_byte", 1, rxb1, 8'h3F);
        chk("framing_frame", 2, f2, 16'hA43F);

        send_byte(8'h55, 1'b1, 87, 87);
        chk("lit_byte_55", 1, rxb1, 8'h55);
        chk("lit_frame_543f", 2, f2, 16'h543F);
        repeat (20) tick();

        msg1 = 1'b0;
        msg2 = 2'b01;
        send_byte(8'h10, 1'b1, 87, 87);
        chk("partial_frame", 2, f2, 16'h543F);
        repeat (20) tick();
        send_byte(8'h21, 1'b1, 87, 87);
        chk("lit_frame_2011", 2, f2, 16'h2011);
        repeat (20) tick();

        send_byte(8'h10, 1'b1, 87, 87);
        repeat (20) tick();
        pulse_reset();
        chk("midframe_rst_frame", 2, f2, 0);
        chk("midframe_rst_byte", 2, rxb2, 0);
        line = 1'b0;
        repeat (300) tick();
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();

        msg2 = 2'b10;
        send_byte(8'h44, 1'b1, 87, 87);
        repeat (20) tick();
        send_byte(8'h45, 1'b1, 87, 87);
        chk("lit_frame_4544", 2, f2, 16'h4544);
        repeat (20) tick();

        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            int bl;
            b    = 8'($urandom);
            msg1 = 1'($urandom);
            msg2 = 2'($urandom);
            if ($urandom_range(7) == 0) begin
                send_byte(b, 1'b0, 87, 87);
                repeat (100) tick();
            end else begin
                bl = $urandom_range(89, 85);
                send_byte(b, 1'b1, bl, bl);
            end
            repeat ($urandom_range(60, 5)) tick();
        end
        repeat (50) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
